// File: rtl/sprite_line_shifter_bank.sv
// Sprite/background line shifter bank: serializes per-channel sprite words
// and a double-buffered background stream into one composited pixel per beat.
module sprite_line_shifter_bank #(
  parameter int NUM_SPRITES = 8,
  parameter int BPP         = 2,
  parameter int WORD_W      = 32,
  parameter int X_W         = 10
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              line_start,
  input  logic                              pixel_en,
  input  logic [NUM_SPRITES-1:0]            load_sprite,
  input  logic [NUM_SPRITES*WORD_W-1:0]     sprite_data,
  input  logic [NUM_SPRITES*X_W-1:0]        sprite_x,
  input  logic [NUM_SPRITES-1:0]            sprite_flip,
  input  logic                              load_bg,
  input  logic [WORD_W-1:0]                 bg_data,
  output logic                              bg_req,
  output logic [BPP-1:0]                    pix_out,
  output logic [$clog2(NUM_SPRITES+1)-1:0]  pix_src,
  output logic                              pix_valid,
  output logic                              collision,
  output logic                              bg_underrun
);
  localparam int PPW = WORD_W / BPP;
  localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int SW  = $clog2(NUM_SPRITES + 1);
  localparam logic [CW-1:0]  LAST = CW'(PPW - 1);
  localparam logic [X_W-1:0] HMAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} ch_state_t;

  function automatic logic [BPP-1:0] pick(
    input logic [WORD_W-1:0] w,
    input logic [CW-1:0]     k,
    input logic              flip
  );
    logic [BPP-1:0] p;
    p = '0;
    for (int j = 0; j < PPW; j++)
      if (CW'(j) == k)
        p = flip ? w[(PPW-1-j)*BPP +: BPP] : w[j*BPP +: BPP];
    return p;
  endfunction

  logic           beat;
  logic [X_W-1:0] hcount;

  // line_start takes precedence over a coincident pixel_en
  assign beat = pixel_en & ~line_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hcount <= '0;
    else if (line_start)
      hcount <= '0;
    else if (beat && hcount != HMAX)
      hcount <= hcount + 1'b1;
  end

  ch_state_t              st_q  [NUM_SPRITES];
  ch_state_t              st_d  [NUM_SPRITES];
  logic [CW-1:0]          cnt_q [NUM_SPRITES];
  logic [CW-1:0]          cnt_d [NUM_SPRITES];
  logic [WORD_W-1:0]      dat_q [NUM_SPRITES];
  logic [X_W-1:0]         x_q   [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] flip_q;
  logic [NUM_SPRITES-1:0] emit;
  logic [BPP-1:0]         spix  [NUM_SPRITES];

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      emit[i]  = 1'b0;
      spix[i]  = '0;
      if (beat) begin
        case (st_q[i])
          WAIT: begin
            if (hcount == x_q[i]) begin
              emit[i]  = 1'b1;
              spix[i]  = pick(dat_q[i], '0, flip_q[i]);
              st_d[i]  = (PPW == 1) ? DONE : SHIFT;
              cnt_d[i] = CW'(1);
            end
          end
          SHIFT: begin
            emit[i] = 1'b1;
            spix[i] = pick(dat_q[i], cnt_q[i], flip_q[i]);
            if (cnt_q[i] == LAST)
              st_d[i] = DONE;
            else
              cnt_d[i] = cnt_q[i] + 1'b1;
          end
          default: ;
        endcase
      end
      // a load re-arms the channel even on a line_start cycle
      if (load_sprite[i]) begin
        st_d[i]  = WAIT;
        cnt_d[i] = '0;
      end else if (line_start) begin
        st_d[i] = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        dat_q[i] <= '0;
        x_q[i]   <= '0;
      end
      flip_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        if (load_sprite[i]) begin
          dat_q[i]  <= sprite_data[i*WORD_W +: WORD_W];
          x_q[i]    <= sprite_x[i*X_W +: X_W];
          flip_q[i] <= sprite_flip[i];
        end
      end
    end
  end

  logic [WORD_W-1:0] act_q, act_d, pend_q, pend_d;
  logic              act_v_q, act_v_d, pend_v_q, pend_v_d;
  logic [CW-1:0]     act_cnt_q, act_cnt_d;
  logic [BPP-1:0]    bg_pix;
  logic              starve;

  always_comb begin
    act_d     = act_q;
    act_v_d   = act_v_q;
    act_cnt_d = act_cnt_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    bg_pix    = '0;
    starve    = 1'b0;
    if (beat) begin
      if (act_v_q) begin
        bg_pix = pick(act_q, act_cnt_q, 1'b0);
        if (act_cnt_q == LAST) begin
          act_d     = pend_q;
          act_v_d   = pend_v_q;
          act_cnt_d = '0;
          pend_v_d  = 1'b0;
        end else begin
          act_cnt_d = act_cnt_q + 1'b1;
        end
      end else begin
        starve = 1'b1;
      end
    end
    // a slot freed by this cycle's swap can take the incoming word
    if (line_start) begin
      act_v_d   = 1'b0;
      pend_v_d  = 1'b0;
      act_cnt_d = '0;
    end else if (load_bg && !pend_v_d) begin
      if (act_v_d) begin
        pend_d   = bg_data;
        pend_v_d = 1'b1;
      end else begin
        act_d     = bg_data;
        act_v_d   = 1'b1;
        act_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q     <= '0;
      pend_q    <= '0;
      act_v_q   <= 1'b0;
      pend_v_q  <= 1'b0;
      act_cnt_q <= '0;
    end else begin
      act_q     <= act_d;
      pend_q    <= pend_d;
      act_v_q   <= act_v_d;
      pend_v_q  <= pend_v_d;
      act_cnt_q <= act_cnt_d;
    end
  end

  assign bg_req = ~pend_v_q;

  logic [BPP-1:0] win_pix;
  logic [SW-1:0]  win_src;
  logic           found;
  logic           coll;

  always_comb begin
    win_pix = bg_pix;
    win_src = SW'(NUM_SPRITES);
    found   = 1'b0;
    coll    = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (emit[i] && spix[i] != '0) begin
        if (found) begin
          coll = 1'b1;
        end else begin
          win_pix = spix[i];
          win_src = SW'(i);
        end
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_out     <= '0;
      pix_src     <= '0;
      pix_valid   <= 1'b0;
      collision   <= 1'b0;
      bg_underrun <= 1'b0;
    end else begin
      pix_valid <= beat;
      collision <= beat & coll;
      if (beat) begin
        pix_out <= win_pix;
        pix_src <= win_src;
      end
      if (line_start)
        bg_underrun <= 1'b0;
      else if (starve)
        bg_underrun <= 1'b1;
    end
  end

endmodule
